// File: rtl/net_axiom_scanner_if.sv
// Bundle between the connectivity scan engine and its host / table store.
// master: the scanner side.  slave: the table/host side.
interface net_axiom_scanner_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 4,
  parameter int SUM_W = 8
);
  logic             start;
  logic             net_req;
  logic [IDX_W-1:0] net_idx;
  logic             net_valid;
  logic [CNT_W-1:0] net_drivers;
  logic [CNT_W-1:0] net_loads;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             viol_valid;
  logic [IDX_W-1:0] viol_idx;
  logic [3:0]       viol_code;
  logic [SUM_W-1:0] cnt_no_drv;
  logic [SUM_W-1:0] cnt_multi_drv;
  logic [SUM_W-1:0] cnt_low_conn;
  logic [SUM_W-1:0] cnt_dangling;

  modport master (
    input  start, net_valid, net_drivers, net_loads,
    output net_req, net_idx, busy, done, timeout_err,
           viol_valid, viol_idx, viol_code,
           cnt_no_drv, cnt_multi_drv, cnt_low_conn, cnt_dangling
  );

  modport slave (
    output start, net_valid, net_drivers, net_loads,
    input  net_req, net_idx, busy, done, timeout_err,
           viol_valid, viol_idx, viol_code,
           cnt_no_drv, cnt_multi_drv, cnt_low_conn, cnt_dangling
  );
endinterface

// File: rtl/net_axiom_scanner.sv
// Connectivity axiom scan engine: walks NUM_NETS table entries, flags
// no-driver / multi-driver / low-connection / dangling nets per entry and
// keeps saturating per-violation summary counts.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  S_IDLE  | waiting for start; counters and flags hold last run
//  S_REQ   | net_req high for the current index, wait timer reloads
//  S_WAIT  | waiting for net_valid, bounded by TIMEOUT cycles
//  S_CHECK | classified net shown on viol_*, counters update at exit
//  S_DONE  | done pulse, then back to idle
module net_axiom_scanner #(
  parameter int NUM_NETS = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 4,
  parameter int SUM_W    = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  net_axiom_scanner_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK, S_DONE} state_t;

  // Wait timer counts down the remaining WAIT cycles; zero marks the last one.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TMR_W-1:0] tmr_q;
  logic             net_req_q;
  logic             busy_q;
  logic             done_q;
  logic             terr_q;
  logic             viol_valid_q;
  logic [3:0]       viol_code_q;
  logic [SUM_W-1:0] cnt_no_drv_q;
  logic [SUM_W-1:0] cnt_multi_drv_q;
  logic [SUM_W-1:0] cnt_low_conn_q;
  logic [SUM_W-1:0] cnt_dangling_q;

  logic [CNT_W:0]   total_d;
  logic [3:0]       code_d;

  function automatic logic [SUM_W-1:0] sat_inc(input logic [SUM_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Classify the response on the bus; only used on the net_valid edge in WAIT.
  always_comb begin
    total_d   = {1'b0, bus.net_drivers} + {1'b0, bus.net_loads};
    code_d    = 4'b0000;
    code_d[3] = (bus.net_drivers == '0) && (bus.net_loads == '0);
    code_d[0] = (bus.net_drivers == '0) && (bus.net_loads != '0);
    code_d[1] = bus.net_drivers > CNT_W'(1);
    code_d[2] = total_d == (CNT_W+1)'(1);
  end

  // Scan FSM with registered outputs and summary counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      tmr_q           <= '0;
      net_req_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      terr_q          <= 1'b0;
      viol_valid_q    <= 1'b0;
      viol_code_q     <= 4'b0000;
      cnt_no_drv_q    <= '0;
      cnt_multi_drv_q <= '0;
      cnt_low_conn_q  <= '0;
      cnt_dangling_q  <= '0;
    end else begin
      net_req_q    <= 1'b0;
      done_q       <= 1'b0;
      viol_valid_q <= 1'b0;
      viol_code_q  <= 4'b0000;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q         <= S_REQ;
            net_req_q       <= 1'b1;
            busy_q          <= 1'b1;
            idx_q           <= '0;
            terr_q          <= 1'b0;
            cnt_no_drv_q    <= '0;
            cnt_multi_drv_q <= '0;
            cnt_low_conn_q  <= '0;
            cnt_dangling_q  <= '0;
          end
        end
        S_REQ: begin
          tmr_q   <= TMR_W'(TIMEOUT - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A response in the final allowed cycle still wins over the timeout.
          if (bus.net_valid) begin
            state_q      <= S_CHECK;
            viol_valid_q <= |code_d;
            viol_code_q  <= code_d;
          end else if (tmr_q == '0) begin
            state_q <= S_DONE;
            terr_q  <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_CHECK: begin
          cnt_no_drv_q    <= sat_inc(cnt_no_drv_q,    viol_code_q[0]);
          cnt_multi_drv_q <= sat_inc(cnt_multi_drv_q, viol_code_q[1]);
          cnt_low_conn_q  <= sat_inc(cnt_low_conn_q,  viol_code_q[2]);
          cnt_dangling_q  <= sat_inc(cnt_dangling_q,  viol_code_q[3]);
          if (idx_q == IDX_W'(NUM_NETS - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q     <= idx_q + 1'b1;
            state_q   <= S_REQ;
            net_req_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.net_req       = net_req_q;
  assign bus.net_idx       = idx_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.timeout_err   = terr_q;
  assign bus.viol_valid    = viol_valid_q;
  assign bus.viol_idx      = idx_q;
  assign bus.viol_code     = viol_code_q;
  assign bus.cnt_no_drv    = cnt_no_drv_q;
  assign bus.cnt_multi_drv = cnt_multi_drv_q;
  assign bus.cnt_low_conn  = cnt_low_conn_q;
  assign bus.cnt_dangling  = cnt_dangling_q;

endmodule

// File: tb/tb_net_axiom_scanner.sv
// Bench for net_axiom_scanner: randomized tables and response delays,
// a scoreboard of expected violations and run summaries, and a monitor.
module tb_net_axiom_scanner;
  localparam int NN  = 6;
  localparam int IW  = 3;
  localparam int CW  = 4;
  localparam int SW  = 2;
  localparam int TO  = 7;
  localparam int SAT = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  net_axiom_scanner_if #(.IDX_W(IW), .CNT_W(CW), .SUM_W(SW)) bus ();

  net_axiom_scanner #(.NUM_NETS(NN), .IDX_W(IW), .CNT_W(CW), .SUM_W(SW), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int tbl_d [NN];
  int tbl_l [NN];
  int dly   [NN];
  int stall_at = -1;

  logic          resp_valid = 1'b0;
  logic          man_valid  = 1'b0;
  logic [CW-1:0] resp_d = '0, resp_l = '0;
  logic [CW-1:0] man_d  = '0, man_l  = '0;

  assign bus.net_valid   = resp_valid | man_valid;
  assign bus.net_drivers = man_valid ? man_d : resp_d;
  assign bus.net_loads   = man_valid ? man_l : resp_l;

  typedef struct { int idx; int code; } viol_t;
  typedef struct { int no_drv; int multi; int low; int dang; int terr; } done_t;
  viol_t viol_q [$];
  done_t done_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference classification straight from the axioms.
  function automatic int model_code(input int d, input int l);
    int c;
    c = 0;
    if (d + l == 0) c = 8;
    else begin
      if (d == 0)     c = c | 1;
      if (d >= 2)     c = c | 2;
      if (d + l == 1) c = c | 4;
    end
    return c;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Table responder: answers each request after 1+dly cycles unless stalled.
  initial begin
    forever begin
      int ri;
      @(negedge clk);
      if (bus.net_req === 1'b1 && !rst) begin
        ri = int'(bus.net_idx);
        if (ri != stall_at) begin
          @(posedge clk);
          repeat (dly[ri]) @(posedge clk);
          #1;
          resp_valid = 1'b1;
          resp_d = CW'(tbl_d[ri]);
          resp_l = CW'(tbl_l[ri]);
          @(posedge clk);
          #1;
          resp_valid = 1'b0;
          resp_d = '0;
          resp_l = '0;
        end
      end
    end
  end

  // Monitor: request sequencing, violation stream and run summaries.
  initial begin
    int nidx;
    bit prev_req;
    viol_t v;
    done_t e;
    nidx = 0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nidx = 0;
        prev_req = 1'b0;
      end else begin
        if (!bus.busy) nidx = 0;
        if (bus.net_req) begin
          chk("req_width", int'(prev_req), 0);
          chk("req_idx", int'(bus.net_idx), nidx);
          nidx++;
        end
        prev_req = bus.net_req;
        if (bus.viol_valid) begin
          if (viol_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL viol_unexpected: idx %0d code %0d, nothing expected",
                     bus.viol_idx, bus.viol_code);
          end else begin
            v = viol_q.pop_front();
            chk("viol_idx", int'(bus.viol_idx), v.idx);
            chk("viol_code", int'(bus.viol_code), v.code);
          end
        end else begin
          chk("viol_code_quiet", int'(bus.viol_code), 0);
        end
        if (bus.done) begin
          chk("busy_in_done", int'(bus.busy), 1);
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: done pulsed, nothing expected");
          end else begin
            e = done_q.pop_front();
            chk("cnt_no_drv", int'(bus.cnt_no_drv), e.no_drv);
            chk("cnt_multi_drv", int'(bus.cnt_multi_drv), e.multi);
            chk("cnt_low_conn", int'(bus.cnt_low_conn), e.low);
            chk("cnt_dangling", int'(bus.cnt_dangling), e.dang);
            chk("timeout_err", int'(bus.timeout_err), e.terr);
          end
        end
      end
    end
  end

  // Push expectations for the nets that will be checked; returns expected summary.
  task automatic expect_nets(input int n_chk, output done_t e, output int lat);
    int code;
    e = '{0, 0, 0, 0, 0};
    lat = 0;
    for (int k = 0; k < n_chk; k++) begin
      code = model_code(tbl_d[k], tbl_l[k]);
      lat += 3 + dly[k];
      if (code != 0) viol_q.push_back('{k, code});
      e.no_drv += code & 1;
      e.multi  += (code >> 1) & 1;
      e.low    += (code >> 2) & 1;
      e.dang   += (code >> 3) & 1;
    end
    e.no_drv = sat(e.no_drv);
    e.multi  = sat(e.multi);
    e.low    = sat(e.low);
    e.dang   = sat(e.dang);
  endtask

  task automatic run_scan(input int stall, input bit mid_start);
    done_t e;
    int lat, cyc;
    expect_nets((stall < 0) ? NN : stall, e, lat);
    lat += (stall < 0) ? 1 : TO + 2;
    e.terr = (stall >= 0) ? 1 : 0;
    done_q.push_back(e);
    stall_at = stall;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 1;
    chk("start_busy", int'(bus.busy), 1);
    chk("start_clr_cnt", int'(bus.cnt_no_drv) + int'(bus.cnt_multi_drv)
        + int'(bus.cnt_low_conn) + int'(bus.cnt_dangling), 0);
    chk("start_clr_terr", int'(bus.timeout_err), 0);
    while (bus.done !== 1'b1 && cyc < lat + 20) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = (mid_start && cyc == 4);
    end
    bus.start = 1'b0;
    chk("done_latency", cyc, lat);
    @(posedge clk);
    #1;
    chk("idle_after_done", int'(bus.busy), 0);
    chk("done_one_cycle", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_dangling", int'(bus.cnt_dangling), e.dang);
    chk("hold_low_conn", int'(bus.cnt_low_conn), e.low);
    chk("hold_terr", int'(bus.timeout_err), e.terr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_req"}, int'(bus.net_req), 0);
    chk({tag, "_viol"}, int'(bus.viol_valid), 0);
    chk({tag, "_terr"}, int'(bus.timeout_err), 0);
    chk({tag, "_cnt"}, int'(bus.cnt_no_drv) + int'(bus.cnt_multi_drv)
        + int'(bus.cnt_low_conn) + int'(bus.cnt_dangling), 0);
  endtask

  task automatic set_tbl(input int k, input int d, input int l);
    tbl_d[k] = d;
    tbl_l[k] = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    done_t e;
    int lat;
    bus.start = 1'b0;
    for (int k = 0; k < NN; k++) begin
      tbl_d[k] = 1; tbl_l[k] = 1; dly[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: classic cases plus wide counts.
    set_tbl(0, 1, 2);  set_tbl(1, 0, 1);  set_tbl(2, 1, 0);
    set_tbl(3, 0, 0);  set_tbl(4, 3, 5);  set_tbl(5, 15, 15);
    run_scan(-1, 1'b0);

    // Timeout at net 2, then a back-to-back normal run clears the flag.
    run_scan(2, 1'b0);
    run_scan(-1, 1'b0);

    // Saturation: all dangling, then all no-driver single-load nets.
    for (int k = 0; k < NN; k++) set_tbl(k, 0, 0);
    run_scan(-1, 1'b0);
    for (int k = 0; k < NN; k++) set_tbl(k, 0, 1);
    run_scan(-1, 1'b0);

    // Stray start mid-scan is ignored.
    set_tbl(0, 2, 0);  set_tbl(3, 1, 1);
    run_scan(-1, 1'b1);

    // Randomized tables and response delays.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < NN; k++) begin
        tbl_d[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
        tbl_l[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
        dly[k]   = int'($urandom_range(0, 3));
      end
      run_scan(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NN - 1)) : -1, r[0]);
    end

    // Reset while waiting on net 2, then a late response.
    for (int k = 0; k < NN; k++) dly[k] = 0;
    set_tbl(0, 0, 0);  set_tbl(1, 0, 2);
    expect_nets(2, e, lat);
    stall_at = 2;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(bus.busy), 1);
    chk("pre_rst_dangling", int'(bus.cnt_dangling), 1);
    chk("pre_rst_no_drv", int'(bus.cnt_no_drv), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    man_valid = 1'b1;
    man_d = '0;
    man_l = '0;
    @(posedge clk);
    #1 man_valid = 1'b0;
    check_all_zero("after_rst");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("late_valid");

    // Recovery run after the abort.
    stall_at = -1;
    run_scan(-1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("viol_queue_drained", viol_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
